// File: rtl/sevenseg_pkg.sv
// Shared types, segment patterns and width helper for the seven-segment scan driver.
package sevenseg_pkg;

  // Active-low segment vector, bit0=a .. bit6=g.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0011000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Counter/index width for a range of n values, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Nibble to active-low seven-segment decoder; 10..15 shown as A..F or blanked.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  output seg_t       o_seg_c
);

  // Pure lookup; hex letters only when hex mode is on.
  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg_c = SEG_0;
      4'h1: o_seg_c = SEG_1;
      4'h2: o_seg_c = SEG_2;
      4'h3: o_seg_c = SEG_3;
      4'h4: o_seg_c = SEG_4;
      4'h5: o_seg_c = SEG_5;
      4'h6: o_seg_c = SEG_6;
      4'h7: o_seg_c = SEG_7;
      4'h8: o_seg_c = SEG_8;
      4'h9: o_seg_c = SEG_9;
      4'hA: o_seg_c = i_hex_mode ? SEG_A : SEG_BLANK;
      4'hB: o_seg_c = i_hex_mode ? SEG_B : SEG_BLANK;
      4'hC: o_seg_c = i_hex_mode ? SEG_C : SEG_BLANK;
      4'hD: o_seg_c = i_hex_mode ? SEG_D : SEG_BLANK;
      4'hE: o_seg_c = i_hex_mode ? SEG_E : SEG_BLANK;
      4'hF: o_seg_c = i_hex_mode ? SEG_F : SEG_BLANK;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment driver with tear-free digit shadowing.
// Optional blink support is compiled in when SEVENSEG_BLINK_EN is defined.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
`ifdef SEVENSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    lz_en,
`ifdef SEVENSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output seg_t                    seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
  localparam int unsigned CNT_W = idx_width(SCAN_DIV);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_dig;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_act_dig;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  seg_t                    r_seg_n;
  logic                    r_dp_n;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_boundary;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_lz;
  logic                    w_blink_sel;
  logic                    w_blink_off;
  seg_t                    w_seg;

  assign w_tick     = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_boundary = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Scan timer and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick) begin
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Pending/active shadow: commit at frame boundary uses pre-cycle pending, a coincident load re-arms pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_dig   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act_dig    <= '0;
      r_act_dp     <= '0;
    end else begin
      if (w_boundary && r_pend_valid) begin
        r_act_dig    <= r_pend_dig;
        r_act_dp     <= r_pend_dp;
        r_pend_valid <= 1'b0;
      end
      if (load) begin
        r_pend_dig   <= digits_in;
        r_pend_dp    <= dp_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Select current digit and work out leading-zero blanking from the top nibble down.
  always_comb begin : sel_digit
    logic v_zero_run;
    w_nib       = '0;
    w_dp        = 1'b0;
    w_lz        = 1'b0;
    w_blink_sel = 1'b0;
    v_zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_zero_run = v_zero_run & (r_act_dig[4*k +: 4] == 4'd0);
      if (r_idx == IDX_W'(k)) begin
        w_nib = r_act_dig[4*k +: 4];
        w_dp  = r_act_dp[k];
        w_lz  = v_zero_run && (k > 0);
`ifdef SEVENSEG_BLINK_EN
        w_blink_sel = blink_mask[k];
`endif
      end
    end
  end

  sevenseg_decode u_decode (
    .i_nibble  (w_nib),
    .i_hex_mode(hex_mode),
    .o_seg_c   (w_seg)
  );

`ifdef SEVENSEG_BLINK_EN
  localparam int unsigned BF_W = idx_width(BLINK_FRAMES);

  logic [BF_W-1:0] r_blink_cnt;
  logic            r_blink_on;

  // Blink phase toggles every BLINK_FRAMES frame boundaries, starting in the on phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_boundary) begin
      if (r_blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BF_W'(1);
      end
    end
  end

  assign w_blink_off = ~r_blink_on & w_blink_sel;
`else
  assign w_blink_off = 1'b0;
`endif

  // Registered pin drivers and end-of-frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_n      <= SEG_BLANK;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_an_n       <= ~(NUM_DIGITS'(1) << r_idx);
      r_frame_done <= w_boundary;
      if (w_blink_off) begin
        r_seg_n <= SEG_BLANK;
        r_dp_n  <= 1'b1;
      end else begin
        r_seg_n <= (lz_en && w_lz) ? SEG_BLANK : w_seg;
        r_dp_n  <= ~w_dp;
      end
    end
  end

  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;

endmodule
